ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xF4 (enable scanning), and runs the inhibit/request-to-send sequence, bit shifting, parity and ACK check. It is the transmit side of the same PS/2 link the keyboard receiver already listens on. It runs on the 10 MHz system `clock` and drives the shared `ps2_clock`/`ps2_data` inouts through open-drain enables resolved at top level. While `busy` is high, the top level gates the keyboard receiver so it does not decode the host's own frame.

## Interface
Parameters:
- INHIBIT_CYCLES, 1200: cycles the clock line is held low before request-to-send (120 µs at 10 MHz).
- TIMEOUT_CYCLES, 200000: maximum cycles allowed between device clock falling edges (20 ms at 10 MHz).

Ports:
- clock  in  1  system clock, 10 MHz.
- resetn  in  1  asynchronous, active-low reset.
- send_cmd  in  1  single-cycle request. Accepted only in IDLE.
- cmd_byte  in  8  byte to send. Sampled in the cycle `send_cmd` is accepted.
- ps2_clk_in  in  1  raw `ps2_clock` pin level.
- ps2_dat_in  in  1  raw `ps2_data` pin level.
- ps2_clk_oe  out  1  1 = pull `ps2_clock` low; 0 = release (high-Z).
- ps2_dat_oe  out  1  1 = pull `ps2_data` low; 0 = release (high-Z).
- busy  out  1  high from acceptance until done/error.
- done  out  1  one-cycle pulse: frame sent and ACK received.
- error  out  1  one-cycle pulse: timeout or missing ACK.

## Operation
- Input conditioning:
  - `ps2_clk_in` and `ps2_dat_in` each pass through a 2-flop synchronizer.
  - A falling edge ("fe") is the synchronized clock going 1 then 0 on consecutive cycles.
- Frame: shift register {stop=1, parity, cmd_byte[7:0]}, sent LSB first. Parity is odd: parity = ~^cmd_byte.
- State machine:
  - IDLE: both oe = 0, busy = 0. On `send_cmd`: latch the frame, busy = 1, go to INHIBIT.
  - INHIBIT: clk_oe = 1, dat_oe = 0. Count INHIBIT_CYCLES, then go to REQ.
  - REQ: clk_oe = 1, dat_oe = 1 (start bit) for exactly 1 cycle, then go to SEND.
  - SEND: clk_oe = 0.
    - dat_oe = ~current bit (start bit is 0, so dat_oe = 1 on entry).
    - On each fe, advance to the next bit. Fe #1–#8 present data bits 0–7, fe #9 presents parity, fe #10 presents stop (dat_oe = 0).
    - The fe after the stop bit (fe #11) samples the synchronized data line:
      - 0: ACK, go to WAIT_REL.
      - 1: pulse error, go to IDLE.
  - WAIT_REL: both oe = 0. When synchronized clock = 1 and data = 1: pulse done, go to IDLE.
- Timeout:
  - A counter clears on entry to SEND and on every fe, and runs in SEND and WAIT_REL.
  - Reaching TIMEOUT_CYCLES: pulse error, release both lines, go to IDLE.
- `send_cmd` while busy is ignored; nothing is queued.
- `send_cmd` and a completion (done/error) in the same cycle: the request is ignored, because the state is not yet IDLE.

## Timing
- Reset (asynchronous, resetn = 0): state IDLE; ps2_clk_oe = 0, ps2_dat_oe = 0, busy = 0, done = 0, error = 0; counters and shift register cleared.
- Reset mid-frame releases both lines immediately, with no clock edge needed.
- busy rises the cycle after `send_cmd` is accepted.
- clk_oe is 1 for INHIBIT_CYCLES + 1 cycles. dat_oe rises together with the final cycle of clk_oe low.
- dat_oe updates 3 cycles after the pin's falling edge (2 synchronizer cycles + 1 register). This is far inside the device's ≥30 µs clock-low time.
- done or error is high for exactly one cycle. busy falls in the same cycle as done or error.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Send 0xED against a device model (clock period 80 µs, ACK on the 11th clock).
  - clk_oe low for 1201 cycles.
  - Sampled line bits (start first): 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once; busy = 0 afterwards.
- Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0, then done.
- Device model never clocks → error pulses exactly TIMEOUT_CYCLES cycles after entering SEND; both oe = 0 afterwards; done never asserted.
- Device leaves data high on the 11th clock (no ACK) → error pulse, no done, state returns to IDLE.
- `send_cmd` with 0x00 pulsed during an 0xED frame → the frame on the wire is still 0xED; exactly one done.
- Assert resetn = 0 after the 5th fe → both oe = 0 and busy = 0 with no clock edge. After release, a new `send_cmd` of 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts one
// command byte out on device clock falling edges and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       send_cmd,
    input  logic [7:0] cmd_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_WAIT_REL
    } state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_q;
    logic          fe;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] cnt;

    // Synchronizers reset to the idle (pulled-up) line level so reset never fakes an edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_q    <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_q    <= clk_sync[1];
        end
    end

    assign fe = clk_q & ~clk_sync[1];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (send_cmd) begin
                        shreg      <= {1'b1, ~^cmd_byte, cmd_byte};
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        cnt        <= '0;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        state      <= S_REQ;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_REQ: begin
                    // Start bit stays driven low while the clock is handed to the device.
                    ps2_clk_oe <= 1'b0;
                    cnt        <= '0;
                    bit_cnt    <= '0;
                    state      <= S_SEND;
                end
                S_SEND: begin
                    if (fe) begin
                        cnt <= '0;
                        if (bit_cnt == 4'd10) begin
                            if (!dat_sync[1]) begin
                                state <= S_WAIT_REL;
                            end else begin
                                error <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end else begin
                            ps2_dat_oe <= ~shreg[0];
                            shreg      <= {1'b0, shreg[9:1]};
                            bit_cnt    <= bit_cnt + 4'd1;
                        end
                    end else if (cnt == TO_LAST) begin
                        error      <= 1'b1;
                        busy       <= 1'b0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_REL: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (clk_sync[1] && dat_sync[1]) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (fe) begin
                        cnt <= '0;
                    end else if (cnt == TO_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a PS/2 device model that
// clocks the frame in, records the line bits and optionally ACKs.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 1200;
    localparam int TO  = 3000;
    localparam int HALF = 400;   // 80 us device clock period at 10 MHz

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       send_cmd = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0, run = 0, clk_low_len = 0, send_start = 0, err_cyc = 0;
    int n_done = 0, n_err = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .resetn(resetn), .send_cmd(send_cmd), .cmd_byte(cmd_byte),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .busy(busy), .done(done), .error(error)
    );

    // Wired-AND bus with pull-ups.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #50 clock = ~clock;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (ps2_clk_oe) run <= run + 1;
        else begin
            if (run != 0) begin
                clk_low_len <= run;
                send_start  <= cyc + 1;
            end
            run <= 0;
        end
        if (done) n_done <= n_done + 1;
        if (error) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        send_cmd = 1'b1;
        cmd_byte = b;
        @(negedge clock);
        send_cmd = 1'b0;
        cmd_byte = 8'h5A;
        chk("busy_rise", busy, 1);
    endtask

    task automatic pulse_cmd(input logic [7:0] b);
        @(negedge clock);
        send_cmd = 1'b1;
        cmd_byte = b;
        @(negedge clock);
        send_cmd = 1'b0;
    endtask

    // Samples the line just before each device clock fall (start bit first).
    task automatic dev_frame(input int n_fall, input bit ack, output logic [10:0] seq);
        int t;
        seq = '0;
        t = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1 && busy) && t < 5000) begin
            @(negedge clock);
            t++;
        end
        chk("rts_seen", (t < 5000) ? 1 : 0, 1);
        repeat (50) @(negedge clock);
        for (int i = 0; i < n_fall; i++) begin
            seq[i] = ps2_dat_in;
            if (i == 10 && ack) begin
                dev_dat_low = 1'b1;
                repeat (10) @(negedge clock);
            end
            dev_clk_low = 1'b1;
            if (i == n_fall - 1 && n_fall < 11) begin
                repeat (10) @(negedge clock);
                return;
            end
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clock);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clock);
            t++;
        end
        chk(tag, (t < 2000) ? 1 : 0, 1);
        repeat (5) @(negedge clock);
    endtask

    initial begin
        logic [10:0] seq;
        int d0, e0;
        logic [10:0] exp_ed, exp_f4;
        exp_ed = 11'b1_1_11101101_0;
        exp_f4 = 11'b1_0_11110100_0;

        repeat (3) @(negedge clock);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        resetn = 1'b1;
        repeat (3) @(negedge clock);

        // 0xED with ACK
        d0 = n_done; e0 = n_err;
        send(8'hED);
        dev_frame(11, 1'b1, seq);
        wait_idle("ed_idle");
        chk("ed_bits", seq, exp_ed);
        chk("ed_clk_low_len", clk_low_len, INH + 1);
        chk("ed_done", n_done - d0, 1);
        chk("ed_no_err", n_err - e0, 0);
        chk("ed_busy_after", busy, 0);

        // 0xF4 with ACK
        d0 = n_done; e0 = n_err;
        send(8'hF4);
        dev_frame(11, 1'b1, seq);
        wait_idle("f4_idle");
        chk("f4_bits", seq, exp_f4);
        chk("f4_done", n_done - d0, 1);
        chk("f4_no_err", n_err - e0, 0);

        // Device never clocks
        d0 = n_done; e0 = n_err;
        send(8'hED);
        begin
            int t;
            t = 0;
            while (n_err == e0 && t < INH + TO + 500) begin
                @(negedge clock);
                t++;
            end
        end
        @(negedge clock);
        chk("to_err", n_err - e0, 1);
        chk("to_delay", err_cyc - send_start, TO);
        chk("to_no_done", n_done - d0, 0);
        chk("to_clk_oe", ps2_clk_oe, 0);
        chk("to_dat_oe", ps2_dat_oe, 0);
        chk("to_busy", busy, 0);
        repeat (5) @(negedge clock);

        // No ACK on the 11th clock
        d0 = n_done; e0 = n_err;
        send(8'hF4);
        dev_frame(11, 1'b0, seq);
        wait_idle("nack_idle");
        chk("nack_bits", seq, exp_f4);
        chk("nack_err", n_err - e0, 1);
        chk("nack_no_done", n_done - d0, 0);
        chk("nack_dat_oe", ps2_dat_oe, 0);

        // send_cmd pulses during a frame are ignored
        d0 = n_done; e0 = n_err;
        send(8'hED);
        fork
            dev_frame(11, 1'b1, seq);
            begin
                repeat (500) @(negedge clock);
                pulse_cmd(8'h00);
                repeat (3000) @(negedge clock);
                pulse_cmd(8'h00);
            end
        join
        wait_idle("coll_idle");
        chk("coll_bits", seq, exp_ed);
        chk("coll_done", n_done - d0, 1);
        chk("coll_no_err", n_err - e0, 0);
        repeat (20) @(negedge clock);
        chk("coll_not_queued", busy, 0);

        // Asynchronous reset after the 5th falling edge
        send(8'hED);
        dev_frame(5, 1'b1, seq);
        chk("abort_pre_dat_oe", ps2_dat_oe, 1);
        chk("abort_pre_busy", busy, 1);
        #10 resetn = 1'b0;
        #5;
        chk("abort_clk_oe", ps2_clk_oe, 0);
        chk("abort_dat_oe", ps2_dat_oe, 0);
        chk("abort_busy", busy, 0);
        dev_clk_low = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        d0 = n_done; e0 = n_err;
        send(8'hF4);
        dev_frame(11, 1'b1, seq);
        wait_idle("post_rst_idle");
        chk("post_rst_bits", seq, exp_f4);
        chk("post_rst_done", n_done - d0, 1);
        chk("post_rst_no_err", n_err - e0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
